cache_axi_arbiter: RTL and testbench



---
 rtl/cache_axi_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_arbiter
// Purpose  : Shares one AXI-like burst master port between the I-cache and
//            D-cache refill engines. Reads are locked per burst (AR to rlast);
//            D-cache writes pass straight through, and pending writes hold off
//            new D-cache read grants. Define ARB_RR_EN for round-robin
//            tie-break; otherwise the D-cache wins ties.
// Revision : 1.0  initial release
// ============================================================================
module cache_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // I-cache read
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [3:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  output logic                i_rvalid,
  input  logic                i_rready,
  // D-cache read
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic [3:0]          d_arlen,
  input  logic [2:0]          d_arsize,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  output logic                d_rvalid,
  input  logic                d_rready,
  // D-cache write
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic [3:0]          d_awlen,
  input  logic [2:0]          d_awsize,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_wlast,
  input  logic                d_wvalid,
  output logic                d_wready,
  output logic                d_bvalid,
  input  logic                d_bready,
  // shared master port
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [3:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR_I = 3'd1,
    AR_D = 3'd2,
    R_I  = 3'd3,
    R_D  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_wr_out;
  logic       w_aw_hs;
  logic       w_b_hs;
  logic       w_d_elig;
  logic       w_pick_d;
  logic       w_r_done;

  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awvalid = d_awvalid;
  assign d_awready = m_awready;
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;
  assign m_wvalid  = d_wvalid;
  assign d_wready  = m_wready;
  assign d_bvalid  = m_bvalid;
  assign m_bready  = d_bready;

  assign w_aw_hs  = d_awvalid & m_awready;
  assign w_b_hs   = m_bvalid & d_bready;
  assign w_d_elig = d_arvalid & (r_wr_out == 2'd0);
  assign w_r_done = m_rvalid & m_rlast &
                    (((r_state == R_I) & i_rready) | ((r_state == R_D) & d_rready));

`ifdef ARB_RR_EN
  // r_rr_d set means the D-cache wins the next tie
  logic r_rr_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_rr_d <= 1'b0;
    else if (w_r_done) r_rr_d <= ~r_rr_d;
  end

  assign w_pick_d = w_d_elig & (~i_arvalid | r_rr_d);
`else
  assign w_pick_d = w_d_elig;
`endif

  // Saturating count of write bursts awaiting their B response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_out <= 2'd0;
    end else if (w_aw_hs && !w_b_hs && r_wr_out != 2'd3) begin
      r_wr_out <= r_wr_out + 2'd1;
    end else if (w_b_hs && !w_aw_hs && r_wr_out != 2'd0) begin
      r_wr_out <= r_wr_out - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_d)       w_state_nxt = AR_D;
        else if (i_arvalid) w_state_nxt = AR_I;
      end
      AR_I:    if (i_arvalid & m_arready) w_state_nxt = R_I;
      AR_D:    if (d_arvalid & m_arready) w_state_nxt = R_D;
      R_I,
      R_D:     if (w_r_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rdata   = '0;
    i_rlast   = 1'b0;
    i_rvalid  = 1'b0;
    d_rdata   = '0;
    d_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    case (r_state)
      AR_I: begin
        m_araddr  = i_araddr;
        m_arlen   = i_arlen;
        m_arsize  = i_arsize;
        m_arvalid = i_arvalid;
        i_arready = m_arready;
      end
      AR_D: begin
        m_araddr  = d_araddr;
        m_arlen   = d_arlen;
        m_arsize  = d_arsize;
        m_arvalid = d_arvalid;
        d_arready = m_arready;
      end
      R_I: begin
        i_rdata  = m_rdata;
        i_rlast  = m_rlast;
        i_rvalid = m_rvalid;
        m_rready = i_rready;
      end
      R_D: begin
        d_rdata  = m_rdata;
        d_rlast  = m_rlast;
        d_rvalid = m_rvalid;
        m_rready = d_rready;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_arbiter
// Purpose  : Self-checking bench for cache_axi_arbiter: directed sequence with
//            randomized beat data, valid gaps and ready stalls.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_axi_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata, m_rdata;
  logic [3:0]  i_arlen, d_arlen, d_awlen, d_wstrb;
  logic [2:0]  i_arsize, d_arsize, d_awsize;
  logic        i_arvalid, i_rready, d_arvalid, d_rready, d_awvalid, d_wlast, d_wvalid, d_bready;
  logic        m_arready, m_rlast, m_rvalid, m_awready, m_wready, m_bvalid;
  logic        i_arready, i_rlast, i_rvalid, d_arready, d_rlast, d_rvalid;
  logic        d_awready, d_wready, d_bvalid;
  logic [31:0] i_rdata, d_rdata, m_araddr, m_awaddr, m_wdata;
  logic [3:0]  m_arlen, m_awlen, m_wstrb;
  logic [2:0]  m_arsize, m_awsize;
  logic        m_arvalid, m_rready, m_awvalid, m_wlast, m_wvalid, m_bready;

  cache_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_chk = 0;
  int n_err = 0;

  // Per-requester request descriptors: index 0 = I-cache, 1 = D-cache
  logic [31:0] req_addr [2];
  logic [3:0]  req_len  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input logic v);
    if (who) begin
      d_arvalid = v; d_araddr = req_addr[1]; d_arlen = req_len[1]; d_arsize = 3'd2;
    end else begin
      i_arvalid = v; i_araddr = req_addr[0]; i_arlen = req_len[0]; i_arsize = 3'd2;
    end
  endtask

  function automatic logic arready_of(input bit who);
    return who ? d_arready : i_arready;
  endfunction
  function automatic logic rvalid_of(input bit who);
    return who ? d_rvalid : i_rvalid;
  endfunction
  function automatic logic rlast_of(input bit who);
    return who ? d_rlast : i_rlast;
  endfunction
  function automatic logic [31:0] rdata_of(input bit who);
    return who ? d_rdata : i_rdata;
  endfunction

  // Expects the shared AR channel to be presenting requester 'who' now
  task automatic ar_phase(input bit who, input int delay);
    for (int k = 0; k < delay; k++) begin
      m_arready = 1'b0;
      #1;
      chk("ar_wait_valid", m_arvalid, 1);
      chk("ar_wait_addr", m_araddr, req_addr[who]);
      chk("ar_wait_ready", arready_of(who), 0);
      chk("ar_other_ready", arready_of(!who), 0);
      tick();
    end
    m_arready = 1'b1;
    #1;
    chk("ar_valid", m_arvalid, 1);
    chk("ar_addr", m_araddr, req_addr[who]);
    chk("ar_len", m_arlen, req_len[who]);
    chk("ar_size", m_arsize, 3'd2);
    chk("ar_ready", arready_of(who), 1);
    chk("ar_other_ready", arready_of(!who), 0);
    tick();
    m_arready = 1'b0;
    set_req(who, 1'b0);
  endtask

  // Delivers len+1 beats to 'who'; optional 3-cycle rready stall at beat stall_at
  task automatic r_phase(input bit who, input int len, input int stall_at);
    int got = 0;
    int cyc = 0;
    int stall_left = 3;
    logic rv, rr, lst;
    logic [31:0] dat;
    while (got <= len && cyc < 300) begin
      cyc++;
      if (got == stall_at && stall_left > 0) begin
        rv = 1'b1; rr = 1'b0; stall_left--;
      end else begin
        rv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 4) != 0);
      end
      dat = $urandom | 32'h1;
      lst = (got == len);
      m_rvalid = rv; m_rdata = dat; m_rlast = lst;
      if (who) begin d_rready = rr; i_rready = 1'b1; end
      else     begin i_rready = rr; d_rready = 1'b1; end
      #1;
      chk("r_valid", rvalid_of(who), rv);
      chk("r_mready", m_rready, rr);
      chk("r_other_valid", rvalid_of(!who), 0);
      chk("r_other_data", rdata_of(!who), 0);
      chk("r_no_ar", m_arvalid, 0);
      chk("r_arready_i", i_arready, 0);
      chk("r_arready_d", d_arready, 0);
      if (rv) begin
        chk("r_data", rdata_of(who), dat);
        chk("r_last", rlast_of(who), lst);
      end
      if (rv && rr) got++;
      tick();
    end
    chk("r_beats", got, len + 1);
    m_rvalid = 1'b0; m_rlast = 1'b0; i_rready = 1'b1; d_rready = 1'b1;
    #1;
    chk("idle_rready", m_rready, 0);
    chk("idle_arvalid", m_arvalid, 0);
  endtask

  bit first;

  initial begin
    {i_arvalid, d_arvalid, i_rready, d_rready, d_awvalid, d_wlast, d_wvalid, d_bready} = '0;
    {m_arready, m_rlast, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    i_araddr = '0; d_araddr = '0; i_arlen = '0; d_arlen = '0; i_arsize = '0; d_arsize = '0;
    d_awaddr = '0; d_awlen = '0; d_awsize = '0; d_wdata = '0; d_wstrb = '0; m_rdata = '0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) tick();

    // Reset state: read side quiet, write side still passes through
    d_awvalid = 1'b1; d_awaddr = 32'h0000_1234; m_awready = 1'b1; m_bvalid = 1'b1;
    m_rdata = 32'hDEAD_BEEF; m_rvalid = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    #1;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_i_arready", i_arready, 0);
    chk("rst_d_arready", d_arready, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_m_araddr", m_araddr, 0);
    chk("rst_awvalid_pass", m_awvalid, 1);
    chk("rst_awaddr_pass", m_awaddr, 32'h0000_1234);
    chk("rst_awready_pass", d_awready, 1);
    chk("rst_bvalid_pass", d_bvalid, 1);
    tick();
    d_awvalid = 1'b0; m_awready = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
    resetn = 1'b1;
    tick();

    // Tie from reset
    req_addr[0] = 32'h1FC0_0100; req_len[0] = 4'd3;
    req_addr[1] = 32'h8000_0040; req_len[1] = 4'd1;
    set_req(0, 1'b1); set_req(1, 1'b1);
    #1 chk("tie_latency", m_arvalid, 0);
    tick();
`ifdef ARB_RR_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    ar_phase(first, $urandom_range(0, 2));
    r_phase(first, int'(req_len[first]), -1);
    tick();
    ar_phase(!first, 0);
    r_phase(!first, int'(req_len[!first]), -1);
    tick();

    // I-cache only, 8 beats
    req_addr[0] = 32'h1FC0_0000; req_len[0] = 4'd7;
    set_req(0, 1'b1);
    #1 chk("i_only_latency", m_arvalid, 0);
    tick();
    ar_phase(0, 0);
    r_phase(0, 7, -1);
    tick();

    // D-cache burst with rready dropped 3 cycles mid-burst
    req_addr[1] = 32'h0000_2000; req_len[1] = 4'd5;
    set_req(1, 1'b1);
    tick();
    ar_phase(1, 1);
    r_phase(1, 5, 2);
    tick();

    // Write-back then read: read held off until B handshake
    d_awaddr = 32'h0000_1000; d_awlen = 4'd7; d_awsize = 3'd2; d_awvalid = 1'b1; m_awready = 1'b1;
    #1;
    chk("wb_awready", d_awready, 1);
    chk("wb_awaddr", m_awaddr, 32'h0000_1000);
    chk("wb_awlen", m_awlen, 4'd7);
    tick();
    d_awvalid = 1'b0; m_awready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      logic [31:0] wd;
      wd = $urandom;
      d_wdata = wd; d_wstrb = 4'hF; d_wlast = (b == 7); d_wvalid = 1'b1; m_wready = 1'b1;
      #1;
      chk("wb_wdata", m_wdata, wd);
      chk("wb_wlast", m_wlast, (b == 7));
      chk("wb_wready", d_wready, 1);
      tick();
    end
    d_wvalid = 1'b0; d_wlast = 1'b0; m_wready = 1'b0;
    req_addr[1] = 32'h0000_1000; req_len[1] = 4'd7;
    set_req(1, 1'b1); d_bready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wb_blocked_arready", d_arready, 0);
      chk("wb_blocked_arvalid", m_arvalid, 0);
      tick();
    end
    m_bvalid = 1'b1;
    #1;
    chk("wb_bvalid", d_bvalid, 1);
    chk("wb_bready", m_bready, 1);
    chk("wb_b_cycle_arvalid", m_arvalid, 0);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wb_after_b_arready", d_arready, 0);
    tick();
    ar_phase(1, 0);
    r_phase(1, 7, -1);
    tick();

    // AW and B in the same cycle leave the count at one; I-cache unaffected
    d_awvalid = 1'b1; m_awready = 1'b1;
    tick();
    m_bvalid = 1'b1;
    tick();
    d_awvalid = 1'b0; m_awready = 1'b0; m_bvalid = 1'b0;
    req_addr[0] = 32'h1FC0_0200; req_len[0] = 4'd1;
    req_addr[1] = 32'h0000_3000; req_len[1] = 4'd2;
    set_req(0, 1'b1); set_req(1, 1'b1);
    tick();
    ar_phase(0, 0);
    r_phase(0, 1, -1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("same_cycle_still_blocked", m_arvalid, 0);
    end
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    #1 chk("after_b_idle", m_arvalid, 0);
    tick();
    ar_phase(1, 0);
    r_phase(1, 2, -1);
    tick();

    // I-cache request arriving during a D-cache burst
    req_addr[1] = 32'h0000_4000; req_len[1] = 4'd3;
    set_req(1, 1'b1);
    tick();
    ar_phase(1, 0);
    req_addr[0] = 32'h1FC0_0300; req_len[0] = 4'd2;
    set_req(0, 1'b1);
    r_phase(1, 3, -1);
    tick();
    ar_phase(0, 0);
    r_phase(0, 2, -1);
    tick();

    // Write in flight, then reset at beat 3 of an 8-beat burst
    d_awvalid = 1'b1; m_awready = 1'b1;
    tick();
    d_awvalid = 1'b0; m_awready = 1'b0;
    req_addr[0] = 32'h1FC0_0400; req_len[0] = 4'd7;
    set_req(0, 1'b1);
    tick();
    ar_phase(0, 0);
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1'b1; m_rdata = $urandom; m_rlast = 1'b0; i_rready = 1'b1;
      #1 chk("pre_rst_rvalid", i_rvalid, 1);
      tick();
    end
    m_rvalid = 1'b1; m_rdata = 32'hA5A5_5A5A;
    resetn = 1'b0;
    #1;
    chk("midrst_rvalid", i_rvalid, 0);
    chk("midrst_rdata", i_rdata, 0);
    chk("midrst_rready", m_rready, 0);
    chk("midrst_arvalid", m_arvalid, 0);
    tick();
    m_rvalid = 1'b0;
    resetn = 1'b1;
    tick();
    // Single-beat D-cache read proves the write count was cleared
    req_addr[1] = 32'h0000_5000; req_len[1] = 4'd0;
    set_req(1, 1'b1);
    #1 chk("post_rst_latency", m_arvalid, 0);
    tick();
    ar_phase(1, 0);
    r_phase(1, 0, -1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
